// File: rtl/id_decode_queue.sv
// id_decode_queue: decodes RV32I (pc, inst) pairs from fetch and queues the micro-ops for in-order issue.
// Latency: an entry pushed at edge N is visible at the head after edge N; there is no empty-queue bypass.
// Backpressure: in_ready is low while the queue is full, regardless of out_ready; rdy=0 freezes all state.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset (overrides flush and rdy)
//   rdy            global clock enable; low holds every register
//   flush          taken jump/branch; empties the queue at the next edge, same-cycle push/pop dropped
//   in_valid/in_ready, in_pc, in_inst           fetch side handshake and payload
//   out_valid/out_ready, out_pc, out_op, out_rd, out_rs1, out_rs2,
//   out_rs1_en, out_rs2_en, out_imm             head micro-op (all zero / NOP while empty)
//   count          occupancy
//   out_illegal    only when ILLEGAL_TRAP_EN is defined: head entry came from an unknown encoding
//
// Optional feature macro: ILLEGAL_TRAP_EN
module id_decode_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int OP_W   = 6,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [INST_W-1:0] in_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [OP_W-1:0]   out_op,
  output logic [4:0]        out_rd,
  output logic [4:0]        out_rs1,
  output logic [4:0]        out_rs2,
  output logic              out_rs1_en,
  output logic              out_rs2_en,
  output logic [31:0]       out_imm,
  output logic [CNT_W-1:0]  count
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic              out_illegal
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  // Major opcodes (inst[6:0])
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  // Micro-op codes (same numbering as the core's shared op table)
  localparam logic [OP_W-1:0] OP_NOP   = OP_W'(0);
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(2);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_JALR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_BLT   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_BGE   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_LB    = OP_W'(11);
  localparam logic [OP_W-1:0] OP_LH    = OP_W'(12);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(13);
  localparam logic [OP_W-1:0] OP_LBU   = OP_W'(14);
  localparam logic [OP_W-1:0] OP_LHU   = OP_W'(15);
  localparam logic [OP_W-1:0] OP_SB    = OP_W'(16);
  localparam logic [OP_W-1:0] OP_SH    = OP_W'(17);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(18);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(19);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(20);
  localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(21);
  localparam logic [OP_W-1:0] OP_XORI  = OP_W'(22);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(23);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(24);
  localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(25);
  localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(26);
  localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(27);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(28);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(29);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(30);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(31);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(32);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(33);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(34);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(35);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(36);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(37);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [OP_W-1:0]   op;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic              rs1_en;
    logic              rs2_en;
    logic [31:0]       imm;
`ifdef ILLEGAL_TRAP_EN
    logic              illegal;
`endif
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            dec;
  entry_t            head;
  logic              ill;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push;
  logic              pop;

  // Instruction fields and immediates
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rd_f, rs1_f, rs2_f;
  logic [31:0] i_imm, s_imm, b_imm, j_imm, u_imm;

  assign opcode = in_inst[6:0];
  assign funct3 = in_inst[14:12];
  assign rd_f   = in_inst[11:7];
  assign rs1_f  = in_inst[19:15];
  assign rs2_f  = in_inst[24:20];
  assign i_imm  = {{20{in_inst[31]}}, in_inst[31:20]};
  assign s_imm  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign b_imm  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign j_imm  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  assign u_imm  = {in_inst[31:12], 12'b0};

  // Decode at push time so the queue stores ready-to-issue micro-ops.
  always_comb begin
    dec    = '0;
    dec.pc = in_pc;
    dec.op = OP_NOP;
    ill    = 1'b0;
    case (opcode)
      OPC_LUI:   begin dec.op = OP_LUI;   dec.rd = rd_f; dec.imm = u_imm; end
      OPC_AUIPC: begin dec.op = OP_AUIPC; dec.rd = rd_f; dec.imm = u_imm; end
      OPC_JAL:   begin dec.op = OP_JAL;   dec.rd = rd_f; dec.imm = j_imm; end
      OPC_JALR: begin
        dec.op     = OP_JALR;
        ill        = (funct3 != 3'd0);
        dec.rd     = rd_f;
        dec.rs1_en = 1'b1;
        dec.imm    = i_imm;
      end
      OPC_BRANCH: begin
        case (funct3)
          3'd0:    dec.op = OP_BEQ;
          3'd1:    dec.op = OP_BNE;
          3'd4:    dec.op = OP_BLT;
          3'd5:    dec.op = OP_BGE;
          3'd6:    dec.op = OP_BLTU;
          3'd7:    dec.op = OP_BGEU;
          default: ill = 1'b1;
        endcase
        dec.rs1_en = 1'b1;
        dec.rs2_en = 1'b1;
        // Branch target is precomputed so EX only resolves the condition.
        dec.imm    = 32'(in_pc) + b_imm;
      end
      OPC_LOAD: begin
        case (funct3)
          3'd0:    dec.op = OP_LB;
          3'd1:    dec.op = OP_LH;
          3'd2:    dec.op = OP_LW;
          3'd4:    dec.op = OP_LBU;
          3'd5:    dec.op = OP_LHU;
          default: ill = 1'b1;
        endcase
        dec.rd     = rd_f;
        dec.rs1_en = 1'b1;
        dec.imm    = i_imm;
      end
      OPC_STORE: begin
        case (funct3)
          3'd0:    dec.op = OP_SB;
          3'd1:    dec.op = OP_SH;
          3'd2:    dec.op = OP_SW;
          default: ill = 1'b1;
        endcase
        dec.rs1_en = 1'b1;
        dec.rs2_en = 1'b1;
        dec.imm    = s_imm;
      end
      OPC_OPIMM: begin
        case (funct3)
          3'd0:    dec.op = OP_ADDI;
          3'd1:    dec.op = OP_SLLI;
          3'd2:    dec.op = OP_SLTI;
          3'd3:    dec.op = OP_SLTIU;
          3'd4:    dec.op = OP_XORI;
          3'd5:    dec.op = in_inst[30] ? OP_SRAI : OP_SRLI;
          3'd6:    dec.op = OP_ORI;
          default: dec.op = OP_ANDI;
        endcase
        dec.rd     = rd_f;
        dec.rs1_en = 1'b1;
        dec.imm    = i_imm;
      end
      OPC_OP: begin
        case (funct3)
          3'd0:    dec.op = in_inst[30] ? OP_SUB : OP_ADD;
          3'd1:    dec.op = OP_SLL;
          3'd2:    dec.op = OP_SLT;
          3'd3:    dec.op = OP_SLTU;
          3'd4:    dec.op = OP_XOR;
          3'd5:    dec.op = in_inst[30] ? OP_SRA : OP_SRL;
          3'd6:    dec.op = OP_OR;
          default: dec.op = OP_AND;
        endcase
        dec.rd     = rd_f;
        dec.rs1_en = 1'b1;
        dec.rs2_en = 1'b1;
      end
      default: ill = 1'b1;
    endcase
    // Unknown encodings collapse to a harmless NOP entry.
    if (ill) begin
      dec.op     = OP_NOP;
      dec.rd     = '0;
      dec.rs1_en = 1'b0;
      dec.rs2_en = 1'b0;
      dec.imm    = '0;
    end
    dec.rs1 = dec.rs1_en ? rs1_f : 5'd0;
    dec.rs2 = dec.rs2_en ? rs2_f : 5'd0;
`ifdef ILLEGAL_TRAP_EN
    dec.illegal = ill;
`endif
  end

  // Queue control
  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready & rdy & ~flush & ~rst;
  assign pop       = out_valid & out_ready & rdy & ~flush & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (rdy) begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end
  end

  // Payload storage needs no reset: head fields are masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  assign head       = mem[rd_ptr];
  assign out_pc     = out_valid ? head.pc     : '0;
  assign out_op     = out_valid ? head.op     : OP_NOP;
  assign out_rd     = out_valid ? head.rd     : 5'd0;
  assign out_rs1    = out_valid ? head.rs1    : 5'd0;
  assign out_rs2    = out_valid ? head.rs2    : 5'd0;
  assign out_rs1_en = out_valid & head.rs1_en;
  assign out_rs2_en = out_valid & head.rs2_en;
  assign out_imm    = out_valid ? head.imm    : 32'd0;
`ifdef ILLEGAL_TRAP_EN
  assign out_illegal = out_valid & head.illegal;
`endif

endmodule

// File: tb/tb_id_decode_queue.sv
module tb_id_decode_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  // Op code numbering of the core's op table
  localparam int OP_NOP = 0, OP_LUI = 1, OP_AUIPC = 2, OP_JAL = 3, OP_JALR = 4;
  localparam int OP_BEQ = 5, OP_BNE = 6, OP_BLT = 7, OP_BGE = 8, OP_BLTU = 9, OP_BGEU = 10;
  localparam int OP_LB = 11, OP_LH = 12, OP_LW = 13, OP_LBU = 14, OP_LHU = 15;
  localparam int OP_SB = 16, OP_SH = 17, OP_SW = 18;
  localparam int OP_ADDI = 19, OP_SLTI = 20, OP_SLTIU = 21, OP_XORI = 22, OP_ORI = 23;
  localparam int OP_ANDI = 24, OP_SLLI = 25, OP_SRLI = 26, OP_SRAI = 27;
  localparam int OP_ADD = 28, OP_SUB = 29, OP_SLL = 30, OP_SLT = 31, OP_SLTU = 32;
  localparam int OP_XOR = 33, OP_SRL = 34, OP_SRA = 35, OP_OR = 36, OP_AND = 37;

  // Immediate format kinds
  localparam int K_U = 0, K_J = 1, K_I = 2, K_B = 3, K_S = 4, K_R = 5;

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_en;
    logic        rs2_en;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  logic             clk;
  logic             rst, rdy, flush;
  logic             in_valid, in_ready;
  logic [31:0]      in_pc, in_inst;
  logic             out_valid, out_ready;
  logic [31:0]      out_pc;
  logic [5:0]       out_op;
  logic [4:0]       out_rd, out_rs1, out_rs2;
  logic             out_rs1_en, out_rs2_en;
  logic [31:0]      out_imm;
  logic [CNT_W-1:0] count;
`ifdef ILLEGAL_TRAP_EN
  logic             out_illegal;
`endif

  id_decode_queue dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rs1_en(out_rs1_en), .out_rs2_en(out_rs2_en), .out_imm(out_imm),
    .count(count)
`ifdef ILLEGAL_TRAP_EN
    , .out_illegal(out_illegal)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  exp_t q[$];

  // funct3-indexed op tables; -1 marks an unassigned funct3
  int br_tbl  [8] = '{OP_BEQ, OP_BNE, -1, -1, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
  int ld_tbl  [8] = '{OP_LB, OP_LH, OP_LW, -1, OP_LBU, OP_LHU, -1, -1};
  int st_tbl  [8] = '{OP_SB, OP_SH, OP_SW, -1, -1, -1, -1, -1};
  int opi_tbl [8] = '{OP_ADDI, OP_SLLI, OP_SLTI, OP_SLTIU, OP_XORI, -1, OP_ORI, OP_ANDI};
  int op_tbl  [8] = '{-1, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, -1, OP_OR, OP_AND};
  logic [6:0] opc_tbl [9] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference decode: op from tables, immediates by signed arithmetic on fields.
  function automatic exp_t ref_dec(input logic [31:0] pc, input logic [31:0] inst);
    exp_t e;
    int op, kind, v;
    logic [2:0] f3;
    f3 = inst[14:12];
    op = -1;
    kind = K_R;
    case (inst[6:0])
      7'h37: begin op = OP_LUI;   kind = K_U; end
      7'h17: begin op = OP_AUIPC; kind = K_U; end
      7'h6f: begin op = OP_JAL;   kind = K_J; end
      7'h67: begin op = (f3 == 3'd0) ? OP_JALR : -1; kind = K_I; end
      7'h63: begin op = br_tbl[f3]; kind = K_B; end
      7'h03: begin op = ld_tbl[f3]; kind = K_I; end
      7'h23: begin op = st_tbl[f3]; kind = K_S; end
      7'h13: begin
        op = (f3 == 3'd5) ? (inst[30] ? OP_SRAI : OP_SRLI) : opi_tbl[f3];
        kind = K_I;
      end
      7'h33: begin
        if (f3 == 3'd0)      op = inst[30] ? OP_SUB : OP_ADD;
        else if (f3 == 3'd5) op = inst[30] ? OP_SRA : OP_SRL;
        else                 op = op_tbl[f3];
        kind = K_R;
      end
      default: op = -1;
    endcase
    e = '0;
    e.pc = pc;
    e.op = 6'(OP_NOP);
    if (op < 0) begin
      e.ill = 1'b1;
      return e;
    end
    e.op = 6'(op);
    if (kind == K_U || kind == K_J || kind == K_I || kind == K_R) e.rd = inst[11:7];
    e.rs1_en = (kind == K_I || kind == K_B || kind == K_S || kind == K_R);
    e.rs2_en = (kind == K_B || kind == K_S || kind == K_R);
    if (e.rs1_en) e.rs1 = inst[19:15];
    if (e.rs2_en) e.rs2 = inst[24:20];
    case (kind)
      K_U: v = int'(inst[31:12]) * 4096;
      K_J: v = int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2
               - (inst[31] ? 1048576 : 0);
      K_I: v = int'(inst[31:20]) - (inst[31] ? 4096 : 0);
      K_S: v = int'(inst[31:25]) * 32 + int'(inst[11:7]) - (inst[31] ? 4096 : 0);
      K_B: v = int'(pc) + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2
               - (inst[31] ? 4096 : 0);
      default: v = 0;
    endcase
    e.imm = v;
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] x;
    int k;
    x = $urandom();
    k = $urandom_range(0, 9);
    if (k < 9) x[6:0] = opc_tbl[k];
    return x;
  endfunction

  task automatic check_all();
    exp_t h;
    logic v;
    v = (q.size() != 0);
    if (v) h = q[0];
    else begin
      h = '0;
      h.op = 6'(OP_NOP);
    end
    chk("count", count, q.size());
    chk("out_valid", out_valid, v);
    chk("in_ready", in_ready, q.size() < DEPTH);
    chk("out_pc", out_pc, h.pc);
    chk("out_op", out_op, h.op);
    chk("out_rd", out_rd, h.rd);
    chk("out_rs1", out_rs1, h.rs1);
    chk("out_rs2", out_rs2, h.rs2);
    chk("out_rs1_en", out_rs1_en, h.rs1_en);
    chk("out_rs2_en", out_rs2_en, h.rs2_en);
    chk("out_imm", out_imm, h.imm);
`ifdef ILLEGAL_TRAP_EN
    chk("out_illegal", out_illegal, v & h.ill);
`endif
  endtask

  // One clock: drive at negedge, model the edge, check at the next negedge.
  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic ordy, input logic r, input logic fl);
    logic do_push, do_pop;
    exp_t e;
    in_valid  = v;
    in_pc     = pc;
    in_inst   = inst;
    out_ready = ordy;
    rdy       = r;
    flush     = fl;
    e = ref_dec(pc, inst);
    do_push = v && (q.size() < DEPTH) && r && !fl;
    do_pop  = (q.size() != 0) && ordy && r && !fl;
    @(posedge clk);
    if (rst) q.delete();
    else if (r) begin
      if (fl) q.delete();
      else begin
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back(e);
      end
    end
    @(negedge clk);
    cyc++;
    check_all();
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; in_pc = '0; in_inst = '0;
    @(negedge clk);

    // Reset
    step(0, 0, 0, 0, 1, 0);
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);

    // ADDI x1, x0, 5
    step(1, 32'h0, 32'h00500093, 0, 1, 0);
    chk("addi_op", out_op, OP_ADDI);
    chk("addi_rd", out_rd, 1);
    chk("addi_rs1", out_rs1, 0);
    chk("addi_rs1_en", out_rs1_en, 1);
    chk("addi_rs2_en", out_rs2_en, 0);
    chk("addi_imm", out_imm, 5);

    // Pop ADDI while pushing BEQ at 0x100 -> target 0x108
    step(1, 32'h100, 32'h00000463, 1, 1, 0);
    chk("beq_op", out_op, OP_BEQ);
    chk("beq_imm", out_imm, 32'h108);
    chk("beq_rd", out_rd, 0);
    chk("beq_rs1_en", out_rs1_en, 1);
    chk("beq_rs2_en", out_rs2_en, 1);
    step(0, 0, 0, 1, 1, 0);

    // Fill with DEPTH+1 offers; the last one must be refused
    for (int i = 0; i < DEPTH + 1; i++) step(1, 32'h200 + 32'(4 * i), rand_inst(), 0, 1, 0);
    chk("full_count", count, DEPTH);
    chk("full_in_ready", in_ready, 0);
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_pc", out_pc, 32'h200 + 32'(4 * i));
      step(0, 0, 0, 1, 1, 0);
    end
    chk("drained_valid", out_valid, 0);

    // Simultaneous push and pop at count=2
    step(1, 32'h10, rand_inst(), 0, 1, 0);
    step(1, 32'h14, rand_inst(), 0, 1, 0);
    step(1, 32'h18, rand_inst(), 1, 1, 0);
    chk("pushpop_count", count, 2);
    step(1, 32'h1c, rand_inst(), 0, 1, 0);
    step(1, 32'h20, rand_inst(), 0, 1, 0);
    chk("prefl_count", count, DEPTH);
    step(1, 32'h24, rand_inst(), 1, 1, 1);
    chk("flush_count", count, 0);
    chk("flush_valid", out_valid, 0);

    // rdy low freezes everything, including flush
    step(1, 32'h300, 32'h00000013, 0, 1, 0);
    step(1, 32'h304, 32'h00000013, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 32'h400, rand_inst(), 1, 0, (i == 2));
    chk("frozen_count", count, 2);
    chk("frozen_pc", out_pc, 32'h300);

    // Reset wins over rdy=0
    rst = 1'b1;
    step(1, 32'h500, rand_inst(), 1, 0, 0);
    rst = 1'b0;
    chk("rst_rdy0_count", count, 0);

    // Unknown encoding becomes NOP
    step(1, 32'h600, 32'hFFFFFFFF, 0, 1, 0);
    chk("illegal_op", out_op, OP_NOP);
    chk("illegal_imm", out_imm, 0);
`ifdef ILLEGAL_TRAP_EN
    chk("illegal_flag", out_illegal, 1);
`endif
    step(0, 0, 0, 1, 1, 0);

    // Randomized traffic with shifting pressure
    for (int i = 0; i < 3000; i++) begin
      logic v, ordy, r, fl;
      v    = ($urandom_range(0, 3) != 0);
      ordy = (i % 600 < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      r    = ($urandom_range(0, 9) != 0);
      fl   = ($urandom_range(0, 60) == 0);
      step(v, $urandom() & 32'hFFFF_FFFC, rand_inst(), ordy, r, fl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
